pipe_stage_reg: RTL and testbench

Parametrised pipeline stage register carrying a control bundle and a data payload between two processor stages (e.g. MEM→WB, EX→MEM). It replaces the fixed per-stage control flip-flops with one reusable block that adds:

- a valid/ready handshake for stalls;
- a synchronous flush that inserts a bubble;
- an optional skid buffer that registers the backpressure path;
- a saturating bubble counter for pipeline performance monitoring.

---
 rtl/pipe_pkg.sv | 8 +
 rtl/pipe_stage_reg.sv | 108 ++++++++++
 tb/tb_pipe_stage_reg.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
// pipe_pkg: shared stage-register state encoding and default control bundle layout.
package pipe_pkg;
  typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} pipe_state_t;
  localparam int CTRL_DEFAULT_W = 3;
  localparam int CTRL_REGWRITE_BIT = 2;
  localparam int CTRL_RESULTSRC_LSB = 0;
  localparam int CTRL_RESULTSRC_W = 2;
endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage register with flush, optional skid slot and bubble counter.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int CTRL_W = 3,
  parameter int DATA_W = 32,
  parameter int SKID = 1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  bubble_cnt
);
  pipe_state_t       r_state;
  logic [CTRL_W-1:0] r_m_ctrl;
  logic [DATA_W-1:0] r_m_data;
  logic              w_in_fire;
  logic              w_out_fire;
  assign out_valid  = r_state != ST_EMPTY;
  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  // Bubbles must never leak RegWrite/MemWrite downstream.
  assign out_ctrl   = out_valid ? r_m_ctrl : '0;
  assign out_data   = r_m_data;
  generate
    if (SKID != 0) begin : g_skid
      logic [CTRL_W-1:0] r_s_ctrl;
      logic [DATA_W-1:0] r_s_data;
      logic              r_in_ready;
      assign in_ready = r_in_ready;
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          r_state    <= ST_EMPTY;
          r_in_ready <= 1'b1;
          r_m_ctrl   <= '0;
          r_m_data   <= '0;
          r_s_ctrl   <= '0;
          r_s_data   <= '0;
        end else if (flush) begin
          r_state    <= ST_EMPTY;
          r_in_ready <= 1'b1;
          r_m_ctrl   <= '0;
          r_s_ctrl   <= '0;
        end else
          case (r_state)
            ST_EMPTY:
              if (w_in_fire) begin
                r_state  <= ST_FULL;
                r_m_ctrl <= in_ctrl;
                r_m_data <= in_data;
              end
            ST_FULL:
              if (w_in_fire && w_out_fire) begin
                r_m_ctrl <= in_ctrl;
                r_m_data <= in_data;
              end else if (w_out_fire)
                r_state <= ST_EMPTY;
              else if (w_in_fire) begin
                r_state    <= ST_SKID;
                r_in_ready <= 1'b0;
                r_s_ctrl   <= in_ctrl;
                r_s_data   <= in_data;
              end
            ST_SKID:
              if (w_out_fire) begin
                r_state    <= ST_FULL;
                r_in_ready <= 1'b1;
                r_m_ctrl   <= r_s_ctrl;
                r_m_data   <= r_s_data;
              end
            default: begin
              r_state    <= ST_EMPTY;
              r_in_ready <= 1'b1;
            end
          endcase
    end else begin : g_noskid
      assign in_ready = out_ready || !out_valid;
      always_ff @(posedge clk or posedge reset)
        if (reset) begin
          r_state  <= ST_EMPTY;
          r_m_ctrl <= '0;
          r_m_data <= '0;
        end else if (flush) begin
          r_state  <= ST_EMPTY;
          r_m_ctrl <= '0;
        end else if (w_in_fire) begin
          r_state  <= ST_FULL;
          r_m_ctrl <= in_ctrl;
          r_m_data <= in_data;
        end else if (w_out_fire)
          r_state <= ST_EMPTY;
    end
  endgenerate
  always_ff @(posedge clk or posedge reset)
    if (reset)
      bubble_cnt <= '0;
    else if ((!out_valid || !out_ready) && bubble_cnt != '1)
      bubble_cnt <= bubble_cnt + CNT_W'(1);
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of the stage register (skid, no-skid and 4-bit counter variants).
module tb_pipe_stage_reg;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        rst_s = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [2:0]  in_ctrl = '0;
  logic [31:0] in_data = '0;
  logic        r_in_ready, r_out_valid, z_in_ready, z_out_valid, s_in_ready, s_out_valid;
  logic [2:0]  r_out_ctrl, z_out_ctrl, s_out_ctrl;
  logic [31:0] r_out_data, z_out_data, s_out_data;
  logic [15:0] r_cnt, z_cnt;
  logic [3:0]  s_cnt;
  int tests = 0;
  int failed = 0;

  always #5 clk = ~clk;

  pipe_stage_reg dut_r (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(r_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(r_out_valid), .out_ready(out_ready),
    .out_ctrl(r_out_ctrl), .out_data(r_out_data), .bubble_cnt(r_cnt));

  pipe_stage_reg #(.SKID(0)) dut_z (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(z_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(z_out_valid), .out_ready(out_ready),
    .out_ctrl(z_out_ctrl), .out_data(z_out_data), .bubble_cnt(z_cnt));

  pipe_stage_reg #(.CNT_W(4)) dut_s (
    .clk(clk), .reset(rst_s), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(s_out_valid), .out_ready(out_ready),
    .out_ctrl(s_out_ctrl), .out_data(s_out_data), .bubble_cnt(s_cnt));

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    assert (got === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [2:0] c, input logic [31:0] d);
    in_valid = v;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    step(); step();
    chk("rst_in_ready", r_in_ready, 1);
    chk("rst_out_valid", r_out_valid, 0);
    chk("rst_out_ctrl", r_out_ctrl, 0);
    chk("rst_out_data", r_out_data, 0);
    chk("rst_cnt", r_cnt, 0);
    reset = 1'b0;
    // streaming at full throughput
    drive(1, 3'b101, 32'h11);
    step();
    chk("s1_data", r_out_data, 32'h11);
    chk("s1_ctrl", r_out_ctrl, 3'b101);
    chk("s1_in_ready", r_in_ready, 1);
    chk("s1_z_data", z_out_data, 32'h11);
    drive(1, 3'b011, 32'h22);
    step();
    chk("s2_data", r_out_data, 32'h22);
    chk("s2_in_ready", r_in_ready, 1);
    drive(1, 3'b110, 32'h33);
    step();
    chk("s3_data", r_out_data, 32'h33);
    chk("s3_ctrl", r_out_ctrl, 3'b110);
    chk("s3_z_data", z_out_data, 32'h33);
    drive(0, 3'b000, 32'h0);
    step();
    chk("s4_out_valid", r_out_valid, 0);
    chk("s4_cnt", r_cnt, 1);
    step();
    chk("s5_cnt", r_cnt, 2);
    // bubble gating
    drive(0, 3'b111, 32'hFF);
    step();
    chk("gate_ctrl", r_out_ctrl, 0);
    chk("gate_valid", r_out_valid, 0);
    chk("gate_z_ctrl", z_out_ctrl, 0);
    // stall and skid
    drive(1, 3'b001, 32'hA1);
    step();
    chk("k_a_data", r_out_data, 32'hA1);
    out_ready = 1'b0;
    drive(1, 3'b010, 32'hB2);
    #1;
    chk("k_z_in_ready_comb", z_in_ready, 0);
    chk("k_r_in_ready_reg", r_in_ready, 1);
    step();
    chk("k_hold_a", r_out_data, 32'hA1);
    chk("k_in_ready0", r_in_ready, 0);
    drive(1, 3'b100, 32'hC3);
    step();
    chk("k_still_a", r_out_data, 32'hA1);
    chk("k_still_ready0", r_in_ready, 0);
    out_ready = 1'b1;
    step();
    chk("k_b_data", r_out_data, 32'hB2);
    chk("k_b_ctrl", r_out_ctrl, 3'b010);
    chk("k_in_ready1", r_in_ready, 1);
    step();
    chk("k_c_data", r_out_data, 32'hC3);
    chk("k_c_ctrl", r_out_ctrl, 3'b100);
    drive(0, 3'b000, 32'h0);
    step();
    chk("k_drained", r_out_valid, 0);
    chk("k_cnt", r_cnt, 6);
    // flush from the SKID state
    out_ready = 1'b0;
    drive(1, 3'b111, 32'hD4);
    step();
    drive(1, 3'b111, 32'hE5);
    step();
    chk("f_skid", r_in_ready, 0);
    flush = 1'b1;
    drive(1, 3'b111, 32'hF6);
    step();
    chk("f_valid", r_out_valid, 0);
    chk("f_ctrl", r_out_ctrl, 0);
    chk("f_in_ready", r_in_ready, 1);
    chk("f_z_valid", z_out_valid, 0);
    flush = 1'b0;
    out_ready = 1'b1;
    drive(0, 3'b000, 32'h0);
    step();
    chk("f_no_ghost", r_out_valid, 0);
    drive(1, 3'b011, 32'h77);
    step();
    chk("f_new_data", r_out_data, 32'h77);
    chk("f_new_ctrl", r_out_ctrl, 3'b011);
    drive(0, 3'b000, 32'h0);
    step();
    // asynchronous reset while in SKID
    out_ready = 1'b0;
    drive(1, 3'b101, 32'h88);
    step();
    drive(1, 3'b101, 32'h99);
    step();
    chk("a_skid", r_in_ready, 0);
    #3 reset = 1'b1;
    #1;
    chk("a_valid", r_out_valid, 0);
    chk("a_ctrl", r_out_ctrl, 0);
    chk("a_data", r_out_data, 0);
    chk("a_cnt", r_cnt, 0);
    chk("a_in_ready", r_in_ready, 1);
    #1 reset = 1'b0;
    out_ready = 1'b1;
    drive(1, 3'b001, 32'h5A);
    step();
    chk("a_first_data", r_out_data, 32'h5A);
    chk("a_first_valid", r_out_valid, 1);
    drive(0, 3'b000, 32'h0);
    step();
    chk("a_no_old", r_out_valid, 0);
    // saturating 4-bit counter
    rst_s = 1'b0;
    for (int i = 0; i < 14; i++) step();
    chk("sat_14", s_cnt, 14);
    for (int i = 0; i < 6; i++) step();
    chk("sat_20", s_cnt, 15);
    step(); step(); step();
    chk("sat_hold", s_cnt, 15);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
